// File: rtl/bnn_neuron_sequencer.sv
// Binary-neuron sequencer: streams CHUNKS xnor chunks through an external popcount,
// accumulates, thresholds. Optional macro BNN_SIGNED_SUM_EN selects a signed ±1 sum_out.
module bnn_neuron_sequencer #(
    parameter int INPUTS       = 8,
    parameter int COUNTER_BITS = 4,
    parameter int CHUNKS       = 4,
    parameter int ACC_BITS     = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear,
    input  logic [ACC_BITS-1:0]     threshold,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUTS-1:0]       in_data,
    input  logic [INPUTS-1:0]       in_weight,
    output logic [INPUTS-1:0]       pc_vec,
    input  logic [COUNTER_BITS-1:0] pc_count,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic [ACC_BITS:0]       sum_out
);

    localparam int BEAT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int TOTAL  = INPUTS * CHUNKS;

    if (CHUNKS < 1) begin : g_bad_chunks
        $error("bnn_neuron_sequencer: CHUNKS must be at least 1");
    end
    if (INPUTS > (2 ** COUNTER_BITS) - 1) begin : g_bad_counter
        $error("bnn_neuron_sequencer: COUNTER_BITS cannot hold INPUTS");
    end
    if (TOTAL > (2 ** ACC_BITS) - 1) begin : g_bad_acc
        $error("bnn_neuron_sequencer: ACC_BITS cannot hold INPUTS*CHUNKS");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_BITS-1:0] acc_q, acc_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ACC_BITS-1:0] thr_q, thr_d;
    logic                out_bit_q, out_bit_d;
    logic [ACC_BITS:0]   sum_q, sum_d;

    assign pc_vec    = ~(in_data ^ in_weight);
    assign in_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_bit   = out_bit_q;
    assign sum_out   = sum_q;

    always_comb begin
        // NOTE: every *_d gets a hold default first so no path through the case infers a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        beat_d    = beat_q;
        thr_d     = thr_q;
        out_bit_d = out_bit_q;
        sum_d     = sum_q;

        if (clear) begin
            state_d   = S_IDLE;
            acc_d     = '0;
            beat_d    = '0;
            out_bit_d = 1'b0;
            sum_d     = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        thr_d   = threshold;
                        acc_d   = '0;
                        beat_d  = '0;
                        state_d = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc_d  = acc_q + ACC_BITS'(pc_count);
                        beat_d = beat_q + 1'b1;
                        if (beat_q == BEAT_W'(CHUNKS - 1)) begin
                            beat_d  = '0;
                            state_d = S_COMPARE;
                        end
                    end
                end
                S_COMPARE: begin
                    out_bit_d = (acc_q >= thr_q);
`ifdef BNN_SIGNED_SUM_EN
                    // 2*acc - N maps the match count onto the ±1 dot product.
                    sum_d     = {acc_q, 1'b0} - (ACC_BITS + 1)'(TOTAL);
`else
                    sum_d     = {1'b0, acc_q};
`endif
                    state_d   = S_DONE;
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            beat_q    <= '0;
            thr_q     <= '0;
            out_bit_q <= 1'b0;
            sum_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            beat_q    <= beat_d;
            thr_q     <= thr_d;
            out_bit_q <= out_bit_d;
            sum_q     <= sum_d;
        end
    end

endmodule

// File: tb/tb_bnn_neuron_sequencer.sv
// Self-checking bench for bnn_neuron_sequencer: vector table plus hand-written corner sequences,
// expected results queued at start and compared at the output handshake.
module tb_bnn_neuron_sequencer;

    localparam int INPUTS       = 8;
    localparam int COUNTER_BITS = 4;
    localparam int CHUNKS       = 4;
    localparam int ACC_BITS     = 6;
    localparam int NVEC         = 7;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic                    clear;
    logic [ACC_BITS-1:0]     threshold;
    logic                    in_valid;
    logic                    in_ready;
    logic [INPUTS-1:0]       in_data;
    logic [INPUTS-1:0]       in_weight;
    logic [INPUTS-1:0]       pc_vec;
    logic [COUNTER_BITS-1:0] pc_count;
    logic                    busy;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_bit;
    logic [ACC_BITS:0]       sum_out;

    bnn_neuron_sequencer #(
        .INPUTS(INPUTS), .COUNTER_BITS(COUNTER_BITS), .CHUNKS(CHUNKS), .ACC_BITS(ACC_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .pc_vec(pc_vec), .pc_count(pc_count), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_bit(out_bit), .sum_out(sum_out)
    );

    always #5 clk = ~clk;

    // External popcount instance, same cycle.
    assign pc_count = COUNTER_BITS'($countones(pc_vec));

    typedef struct {
        logic [CHUNKS-1:0][INPUTS-1:0] data;
        logic [CHUNKS-1:0][INPUTS-1:0] weight;
        logic [ACC_BITS-1:0]           thr;
        int                            acc;
        logic                          exp_bit;
    } vec_t;

    typedef struct {
        logic              exp_bit;
        logic [ACC_BITS:0] exp_sum;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ACC_BITS:0] model_sum(input int acc);
`ifdef BNN_SIGNED_SUM_EN
        return (ACC_BITS + 1)'(2 * acc - INPUTS * CHUNKS);
`else
        return (ACC_BITS + 1)'(acc);
`endif
    endfunction

    // vpat/plen: in_valid pattern per ACCUM cycle (LSB first); plen==0 means always valid.
    task automatic run_eval(input vec_t v, input logic [15:0] vpat, input int plen,
                            input int hold, input bit meddle, input bit check_lat);
        int   cyc;
        int   beats;
        int   k;
        bit   vld;
        bit   took;
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        threshold = v.thr;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sb.push_back('{exp_bit: v.exp_bit, exp_sum: model_sum(v.acc)});
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", busy, 1);
        beats = 0;
        k     = 0;
        while (beats < CHUNKS && cyc < 100) begin
            vld       = (plen == 0 || k >= 16) ? 1'b1 : vpat[k];
            in_valid  = vld;
            in_data   = v.data[beats];
            in_weight = v.weight[beats];
            if (meddle && beats == 1) begin
                start     = 1'b1;
                threshold = ~v.thr;
            end
            took = vld && in_ready;
            @(negedge clk);
            cyc++;
            k++;
            if (took) beats++;
            start = 1'b0;
        end
        in_valid = 1'b0;
        check("beats_accepted", beats, CHUNKS);
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("out_valid_seen", out_valid, 1);
        if (check_lat) check("out_valid_latency", cyc, CHUNKS + 2);
        for (int h = 0; h < hold; h++) begin
            start = meddle;
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_bit", out_bit, sb[0].exp_bit);
            check("hold_sum_out", sum_out, sb[0].exp_sum);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        check("out_bit", out_bit, e.exp_bit);
        check("sum_out", sum_out, e.exp_sum);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("idle_after_handshake", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rose;

        vecs[0] = '{data: 32'hFFFF_FFFF, weight: 32'hFFFF_FFFF, thr: 6'd16, acc: 32, exp_bit: 1'b1};
        vecs[1] = '{data: 32'h0F0F_0F0F, weight: 32'h0000_0000, thr: 6'd16, acc: 16, exp_bit: 1'b1};
        vecs[2] = '{data: 32'h0F0F_0F0F, weight: 32'h0000_0000, thr: 6'd17, acc: 16, exp_bit: 1'b0};
        vecs[3] = '{data: 32'h0000_0000, weight: 32'h0000_0000, thr: 6'd32, acc: 32, exp_bit: 1'b1};
        vecs[4] = '{data: 32'hFFFF_FFFF, weight: 32'h0000_0000, thr: 6'd0,  acc: 0,  exp_bit: 1'b1};
        vecs[5] = '{data: 32'h01F0_55AA, weight: 32'h000F_AAAA, thr: 6'd15, acc: 15, exp_bit: 1'b1};
        vecs[6] = '{data: 32'hFFFF_FFFF, weight: 32'hFFFF_FFFF, thr: 6'd63, acc: 32, exp_bit: 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        threshold = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_weight = '0;
        out_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_sum_out", sum_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) run_eval(vecs[i], 16'h0, 0, (i == 0) ? 0 : 1, 1'b0, 1'b1);

        // Gapped valid stream 1,0,0,1,1,0,1 plus a 5-cycle output stall.
        run_eval(vecs[1], 16'b1011001, 7, 5, 1'b0, 1'b0);

        // clear together with the third accepted beat.
        @(negedge clk);
        start     = 1'b1;
        threshold = '0;
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_weight = 8'hFF;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear_busy", busy, 0);
        check("clear_in_ready", in_ready, 0);
        check("clear_out_bit", out_bit, 0);
        check("clear_sum_out", sum_out, 0);
        rose = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) rose = 1'b1;
            @(negedge clk);
        end
        check("clear_no_out_valid", rose, 0);
        run_eval(vecs[0], 16'h0, 0, 0, 1'b0, 1'b1);

        // Stray start pulses and a threshold change mid-run.
        run_eval(vecs[1], 16'h0, 0, 2, 1'b1, 1'b1);

        // Asynchronous reset in the middle of ACCUM.
        @(negedge clk);
        start     = 1'b1;
        threshold = 6'd5;
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h00;
        in_weight = 8'h00;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_bit", out_bit, 0);
        check("midrst_sum_out", sum_out, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        rose = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid || busy) rose = 1'b1;
            @(negedge clk);
        end
        check("midrst_quiet", rose, 0);
        run_eval(vecs[5], 16'h0, 0, 1, 1'b0, 1'b1);

        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bnn_neuron_sequencer.md
Name: bnn_neuron_sequencer

Overview:
Controller that time-multiplexes one external popcount datapath to evaluate a binary neuron over CHUNKS*INPUTS inputs.
- Accepts input/weight chunks over a valid/ready handshake and drives the XNOR vector to the popcount.
- Accumulates the returned counts and compares the total against a programmable threshold.
- Presents the activation bit and the sum over an output valid/ready handshake.
- Sits between the input streamer and the popcount instance inside each neuron tile.

Parameters:
INPUTS, 8, chunk width; equals the popcount INPUTS.
COUNTER_BITS, 4, popcount result width; must hold INPUTS.
CHUNKS, 4, chunks per neuron evaluation; >= 1.
ACC_BITS, 6, accumulator width; must hold INPUTS*CHUNKS.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin an evaluation; sampled in IDLE only.
clear  in  1  synchronous abort to IDLE; accumulator and beat counter zeroed.
threshold  in  ACC_BITS  activation threshold; latched on accepted start.
in_valid  in  1  chunk valid.
in_ready  out  1  chunk accepted when in_valid && in_ready.
in_data  in  INPUTS  activation chunk.
in_weight  in  INPUTS  weight chunk.
pc_vec  out  INPUTS  vector to popcount: ~(in_data ^ in_weight), combinational.
pc_count  in  COUNTER_BITS  popcount result of pc_vec, same cycle.
busy  out  1  high in every state except IDLE.
out_valid  out  1  result valid.
out_ready  in  1  result consumed when out_valid && out_ready.
out_bit  out  1  activation: acc >= threshold (unsigned).
sum_out  out  ACC_BITS+1  accumulated sum (format per Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc=0; beat=0; threshold latch=0; in_ready=0, out_valid=0, out_bit=0, sum_out=0, busy=0.
- FSM states: IDLE, ACCUM, COMPARE, DONE.
- IDLE: start=1 -> latch threshold, acc=0, beat=0, go to ACCUM.
- ACCUM: in_ready=1.
  - Each accepted beat: acc <= acc + zero-extended pc_count; beat <= beat+1.
  - The beat with beat==CHUNKS-1 moves to COMPARE.
  - in_valid low: wait, no change.
- COMPARE, one cycle: register out_bit=(acc>=threshold latch) and sum_out; go to DONE.
- DONE: out_valid=1, outputs held stable until out_ready=1; on handshake go to IDLE.
- out_valid drops in the cycle after the handshake. No back-to-back start in that same cycle: start is honoured one cycle later in IDLE.
- pc_vec is driven with the XNOR in all states. in_ready is low outside ACCUM, so no beat is counted.
- Accumulator never wraps within legal parameters. An overflowing parameter set is illegal: reject via elaboration-time check (generate-time error).
- start outside IDLE is ignored. threshold changes after the latch have no effect.
- clear in any state -> IDLE next cycle: acc=0, beat=0, out_valid=0, out_bit=0, sum_out=0. clear has priority over start, beat acceptance and the out handshake.
- Latency: start accepted at cycle 0 with in_valid held high -> beats at cycles 1..CHUNKS -> COMPARE at CHUNKS+1 -> out_valid high from cycle CHUNKS+2.
- rst_n asserted mid-evaluation: immediate return to reset values; no partial result is emitted.

Optional Feature:
Macro BNN_SIGNED_SUM_EN.
- Defined: sum_out = 2*acc - INPUTS*CHUNKS, two's complement in ACC_BITS+1 bits (signed ±1 dot product). out_bit is unchanged (still acc >= threshold).
- Undefined: sum_out = acc, zero-extended to ACC_BITS+1.

Test Plan:
1. Reset: assert rst_n low mid-ACCUM -> all outputs 0, busy=0 at once; after release, a start/evaluation completes normally.
2. Default params, threshold=16; all chunks in_data=8'hFF, in_weight=8'hFF -> acc=32, out_bit=1, sum_out=32 (signed build: +32); out_valid at cycle 6.
3. in_data=8'h0F, in_weight=8'h00 on all 4 chunks -> pc_count 4 each, acc=16. Threshold=16 -> out_bit=1; threshold=17 -> out_bit=0; signed build sum_out=0.
4. in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats counted; result equals the gap-free run. out_ready held low 5 cycles -> out_valid and outputs stable throughout.
5. clear asserted together with the 3rd accepted beat -> IDLE next cycle, acc=0, out_valid never rises. A following full run gives the correct result.
6. start pulsed during ACCUM and during DONE -> ignored; threshold change mid-run -> result uses the latched value.
